// File: rtl/replace_num_msg_rx.sv
// replace_num_msg_rx: parses replace-number messages from the UART RX byte
// stream, verifies the XOR checksum, issues a single-cycle write of the
// {addr, data} packet to the replacement-number memory and answers the host
// with an ACK (8'h06) or NAK (8'h15) byte on the UART TX interface.
//
// state   | meaning
// --------+-----------------------------------------------------------------
// IDLE    | hunting for the header byte; all other bytes discarded
// PAYLOAD | shifting in address/data bytes, then the checksum byte
// CHECK   | compare received checksum against running XOR
// WRITE   | write strobe is high this cycle; queue the ACK byte
// RESP    | hold tx_valid/tx_data until the transmitter accepts
module replace_num_msg_rx #(
  parameter int          ADDR_WIDTH     = 16,
  parameter int          DATA_WIDTH     = 32,
  parameter int          TIMEOUT_CYCLES = 100000,
  parameter logic [7:0]  HDR_BYTE       = 8'h52
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [7:0]                       rx_data,
  input  logic                             rx_valid,
  output logic [7:0]                       tx_data,
  output logic                             tx_valid,
  input  logic                             tx_ready,
  output logic [ADDR_WIDTH+DATA_WIDTH-1:0] wr_packet,
  output logic                             wr_en,
  output logic                             err,
  output logic                             timeout
);

  localparam int W     = ADDR_WIDTH + DATA_WIDTH;
  localparam int N     = W / 8;
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int BC_W  = $clog2(N + 1);

  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [BC_W-1:0]  N_BYTES = BC_W'(N);
  localparam logic [7:0]       ACK     = 8'h06;
  localparam logic [7:0]       NAK     = 8'h15;

  typedef enum logic [2:0] {
    IDLE,
    PAYLOAD,
    CHECK,
    WRITE,
    RESP
  } state_t;

  state_t           state;
  logic [W-1:0]     sr;
  logic [7:0]       xor_acc;
  logic [7:0]       csum;
  logic [BC_W-1:0]  byte_cnt;
  logic [CNT_W-1:0] to_cnt;

  // Message parser FSM with registered outputs; pulses default low each cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      sr        <= '0;
      xor_acc   <= '0;
      csum      <= '0;
      byte_cnt  <= '0;
      to_cnt    <= '0;
      wr_packet <= '0;
      wr_en     <= 1'b0;
      err       <= 1'b0;
      timeout   <= 1'b0;
      tx_valid  <= 1'b0;
      tx_data   <= '0;
    end else begin
      wr_en   <= 1'b0;
      err     <= 1'b0;
      timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (rx_valid && (rx_data == HDR_BYTE)) begin
            state    <= PAYLOAD;
            byte_cnt <= '0;
            xor_acc  <= '0;
            sr       <= '0;
            to_cnt   <= '0;
          end
        end
        PAYLOAD: begin
          // An arriving byte always beats a coincident timeout expiry.
          if (rx_valid) begin
            to_cnt <= '0;
            if (byte_cnt == N_BYTES) begin
              csum  <= rx_data;
              state <= CHECK;
            end else begin
              sr       <= {sr[W-9:0], rx_data};
              xor_acc  <= xor_acc ^ rx_data;
              byte_cnt <= byte_cnt + 1'b1;
            end
          end else if (to_cnt == TO_LAST) begin
            timeout <= 1'b1;
            state   <= IDLE;
          end else begin
            // Stops at TO_LAST, so the counter saturates instead of wrapping.
            to_cnt <= to_cnt + 1'b1;
          end
        end
        CHECK: begin
          if (csum == xor_acc) begin
            // Strobe lands in the WRITE cycle together with the packet.
            wr_en     <= 1'b1;
            wr_packet <= sr;
            state     <= WRITE;
          end else begin
            err      <= 1'b1;
            tx_data  <= NAK;
            tx_valid <= 1'b1;
            state    <= RESP;
          end
        end
        WRITE: begin
          tx_data  <= ACK;
          tx_valid <= 1'b1;
          state    <= RESP;
        end
        RESP: begin
          if (tx_ready) begin
            tx_valid <= 1'b0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
